seq_divider: RTL and testbench

//  Parametrised multi-cycle restoring divider for the calculator datapath; next generation of the 4-bit combinational array divider.

---
 rtl/seq_divider.sv | 139 +++++++++++++
 tb/tb_seq_divider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with divide-by-zero and overflow flags.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; otherwise all values are unsigned.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dbz,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Handshake: start is sampled only while idle (busy low), including the cycle
    // done is high; done pulses once per accepted start and the result registers
    // (quo/rem/dbz/ovf) are valid from that cycle until the next done.
    logic [1:0]       state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] prem;
    logic [CNT_W-1:0] cnt;
    logic             dbz_p;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] rem_n;

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic ovf_p;
    logic ovf_r;

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        shifted = {prem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
`ifdef SEQ_DIV_SIGNED_EN
        mag_a = a[WIDTH-1] ? -a : a;
        mag_b = b[WIDTH-1] ? -b : b;
        quo_n = neg_q ? -dvd : dvd;
        rem_n = neg_r ? -prem : prem;
`else
        mag_a = a;
        mag_b = b;
        quo_n = dvd;
        rem_n = prem;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dvd   <= '0;
            dvs   <= '0;
            prem  <= '0;
            cnt   <= '0;
            dbz_p <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf_p <= 1'b0;
            ovf_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        prem  <= '0;
                        cnt   <= CNT_W'(WIDTH - 1);
                        dbz_p <= (b == '0);
`ifdef SEQ_DIV_SIGNED_EN
                        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r <= a[WIDTH-1];
                        ovf_p <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
`endif
                        // A zero divisor keeps the raw dividend so it can be returned as rem.
                        if (b == '0) begin
                            dvd   <= a;
                            state <= FIX;
                        end else begin
                            dvd   <= mag_a;
                            dvs   <= mag_b;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Quotient bits shift into the vacated dividend LSBs.
                    dvd  <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    prem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    dbz   <= dbz_p;
                    if (dbz_p) begin
                        quo <= '1;
                        rem <= dvd;
                    end else begin
                        quo <= quo_n;
                        rem <= rem_n;
                    end
`ifdef SEQ_DIV_SIGNED_EN
                    ovf_r <= ovf_p;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed and random divisions checked through an expected-result queue.
// Signed-only cases run when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider;
    localparam int W = 8;
    localparam int BUDGET = 4 * W + 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    logic         ovf;
    logic [1:0]   dbg_state;

    logic [2*W+1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_start = 0;
    int done_seen = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quo(quo), .rem(rem),
        .dbz(dbz), .ovf(ovf), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_);
        logic [W-1:0] q;
        logic [W-1:0] r;
        int ia;
        int ib;
        if (tb_ == '0) return {{W{1'b1}}, ta, 2'b10};
`ifdef SEQ_DIV_SIGNED_EN
        if (ta == {1'b1, {(W-1){1'b0}}} && tb_ == '1) return {ta, {W{1'b0}}, 2'b01};
        ia = $signed(ta);
        ib = $signed(tb_);
        q = W'(ia / ib);
        r = W'(ia % ib);
`else
        ia = 0;
        ib = 0;
        q = ta / tb_;
        r = ta % tb_;
`endif
        return {q, r, 2'b00};
    endfunction

    // scoreboard: every done pops one expected result
    always @(negedge clk) begin
        logic [2*W+1:0] e;
        if (done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("quo", 32'(quo), 32'(e[2*W+1:W+2]));
                check("rem", 32'(rem), 32'(e[W+1:2]));
                check("dbz", 32'(dbz), 32'(e[1]));
                check("ovf", 32'(ovf), 32'(e[0]));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_);
        @(negedge clk);
        start = 1'b1;
        a = ta;
        b = tb_;
        exp_q.push_back(model(ta, tb_));
        @(posedge clk);
        #1;
        t_start = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input bit chk_busy);
        int bcnt = 0;
        bit got = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(cyc - t_start), 32'(exp_lat));
            if (chk_busy) check("busy_cycles", 32'(bcnt), 32'(exp_lat));
            @(negedge clk);
            check("done_width", 32'(done), 32'd0);
        end
    endtask

    task automatic wait_done_at(output int t);
        t = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t1;
        int t2;
        int seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quo", 32'(quo), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // main function, busy length and single-cycle done
        start_op(8'd100, 8'd7);
        wait_done(W + 1, 1'b1);

`ifdef SEQ_DIV_SIGNED_EN
        start_op(8'hF9, 8'h02);
        wait_done(W + 1, 1'b1);
        start_op(8'h80, 8'hFF);
        wait_done(W + 1, 1'b0);
        start_op(8'd6, 8'd3);
        wait_done(W + 1, 1'b0);
        start_op(8'h07, 8'hFE);
        wait_done(W + 1, 1'b0);
`endif

        // divide by zero finishes one clock after start
        start_op(8'h35, 8'h00);
        wait_done(1, 1'b1);

        // start during CALC is ignored
        start_op(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a = 8'd3;
        b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(W + 1, 1'b0);

        // reset in the 4th CALC cycle aborts with no done
        start_op(8'd200, 8'd9);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quo", 32'(quo), 32'd0);
        check("abort_rem", 32'(rem), 32'd0);
        exp_q.delete();
        seen = done_seen;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * W) @(negedge clk);
        check("abort_no_done", 32'(done_seen), 32'(seen));
        start_op(8'd200, 8'd9);
        wait_done(W + 1, 1'b1);

        // start held high: second op accepted on the done cycle
        @(negedge clk);
        start = 1'b1;
        a = 8'hF9;
        b = 8'h02;
        exp_q.push_back(model(8'hF9, 8'h02));
        exp_q.push_back(model(8'hF9, 8'h02));
        wait_done_at(t1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accepted", 32'(busy), 32'd1);
        wait_done_at(t2);
        check("b2b_gap", 32'(t2 - t1), 32'(W + 2));

        // random operands, with an occasional zero divisor
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = (i == 5) ? '0 : W'($urandom_range(1, (1 << W) - 1));
            start_op(ra, rb);
            wait_done((rb == '0) ? 1 : W + 1, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
